// File: rtl/pwmtimer_nbits.sv
// pwmtimer_nbits: WIDTH-bit down/up/up-down PWM carrier timer with shadowed period/mode,
// phase-sync reload, direction output and maskable zero/max sync events.
module pwmtimer_nbits #(
  parameter int WIDTH = 16,
  parameter logic [15:0] RST_CMAX = 16'h00FF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [1:0]       count_mode,
  input  logic [WIDTH-1:0] countmax,
  input  logic [WIDTH-1:0] init_carr,
  input  logic             init_dir,
  input  logic             sync_in,
  input  logic [1:0]       syncmode,
  output logic [WIDTH-1:0] carrier,
  output logic             dir,
  output logic             sync
);
  typedef enum logic [1:0] {NO_COUNT, DOWN, UP, UPDOWN} mode_t;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  mode_t            mode_act;
  logic [WIDTH-1:0] cmax_act;
  logic [WIDTH-1:0] carrier_nx;
  logic             dir_nx;
  logic             zevt;
  logic             mevt;
  logic             bnd;
  logic             load;
  logic             sync_nx;
  logic             peak;
  logic             trough;
  always_comb begin
    zevt    = (mode_act != NO_COUNT) && (carrier == '0);
    mevt    = (mode_act != NO_COUNT) && (carrier == cmax_act);
    bnd     = (mode_act == DOWN)   ? zevt :
              (mode_act == UP)     ? (carrier >= cmax_act) :
              (mode_act == UPDOWN) ? (zevt && !dir) : 1'b0;
    load    = !sync_in && ((mode_act == NO_COUNT) || bnd);
    sync_nx = ce && ((zevt && syncmode[0]) || (mevt && syncmode[1]));
    peak    = dir && (carrier >= cmax_act);
    trough  = !dir && (carrier == '0);
    carrier_nx = carrier;
    dir_nx     = dir;
    if (sync_in) begin
      carrier_nx = init_carr;
      dir_nx     = (mode_act == UPDOWN) ? init_dir : (mode_act == UP);
    end else begin
      unique case (mode_act)
        DOWN: begin
          carrier_nx = (carrier == '0) ? cmax_act : carrier - ONE;
          dir_nx     = 1'b0;
        end
        UP: begin
          carrier_nx = (carrier >= cmax_act) ? '0 : carrier + ONE;
          dir_nx     = 1'b1;
        end
        UPDOWN: begin
          // a zero period would otherwise underflow at the peak; hold at 0 and just flip direction
          carrier_nx = (cmax_act == '0) ? '0 :
                       peak             ? cmax_act - ONE :
                       trough           ? ONE :
                       dir              ? carrier + ONE : carrier - ONE;
          dir_nx     = (cmax_act == '0) ? !dir :
                       peak             ? 1'b0 :
                       trough           ? 1'b1 : dir;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carrier  <= '0;
      dir      <= 1'b1;
      sync     <= 1'b0;
      cmax_act <= WIDTH'(RST_CMAX);
      mode_act <= NO_COUNT;
    end else begin
      sync <= sync_nx;
      if (ce) begin
        carrier <= carrier_nx;
        dir     <= dir_nx;
        if (load) begin
          cmax_act <= countmax;
          mode_act <= mode_t'(count_mode);
        end
      end
    end
  end
endmodule
